// File: rtl/sd_spi_ctrl.sv
// SD card SPI master: power-up dummy clocks, then one mode-0 byte exchange
// per host request at a slow (init) or fast SCLK rate, plus a stretched
// activity LED.
module sd_spi_ctrl #(
  parameter int SLOW_DIV  = 62,
  parameter int FAST_DIV  = 1,
  parameter int INIT_CLKS = 80,
  parameter int LED_HOLD  = 1000000
) (
  input  logic       clk,
  input  logic       N_RESET,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       fast,
  input  logic       cs_req,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       sdCS,
  output logic       sdSCLK,
  output logic       sdMOSI,
  input  logic       sdMISO,
  output logic       driveLED
);

  localparam int MAX_DIV    = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int DIV_W      = (MAX_DIV < 1) ? 1 : $clog2(MAX_DIV + 1);
  localparam int INIT_EDGES = 2 * INIT_CLKS;
  localparam int EDGE_W     = ($clog2(INIT_EDGES) > 4) ? $clog2(INIT_EDGES) : 4;
  localparam int LED_W      = ($clog2(LED_HOLD + 1) > 16) ? $clog2(LED_HOLD + 1) : 16;

  localparam logic [DIV_W-1:0]  SLOW_LAST  = DIV_W'(SLOW_DIV);
  localparam logic [DIV_W-1:0]  FAST_LAST  = DIV_W'(FAST_DIV);
  localparam logic [EDGE_W-1:0] INIT_LAST  = EDGE_W'(INIT_EDGES - 1);
  localparam logic [EDGE_W-1:0] SHIFT_LAST = EDGE_W'(15);
  localparam logic [LED_W-1:0]  LED_LOAD   = LED_W'(LED_HOLD);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic [EDGE_W-1:0] edge_cnt;
  logic [LED_W-1:0]  led_cnt;
  logic              sclk_q;
  logic              mosi_q;
  logic              fast_q;
  logic [6:0]        tx_shift;
  logic [7:0]        rx_shift;

  logic              accept;
  logic              tick;
  logic [DIV_W-1:0]  div_last;
  logic [EDGE_W-1:0] edge_last;

  // INIT always runs at the slow rate; SHIFT uses the rate latched with start
  assign accept    = (state == S_IDLE) && start;
  assign div_last  = (state == S_SHIFT && fast_q) ? FAST_LAST : SLOW_LAST;
  assign edge_last = (state == S_INIT) ? INIT_LAST : SHIFT_LAST;
  assign tick      = (div_cnt == div_last);

  // State register
  always_ff @(posedge clk or negedge N_RESET) begin
    if (!N_RESET) state <= S_INIT;
    else          state <= state_nxt;
  end

  // Next-state: leave INIT/SHIFT on the tick that ends the last half-period
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (tick && edge_cnt == INIT_LAST) state_nxt = S_IDLE;
      S_IDLE:  if (accept) state_nxt = S_SHIFT;
      S_SHIFT: if (tick && edge_cnt == SHIFT_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  // Divider, half-period counter, SCLK/MOSI generation and byte shifting
  always_ff @(posedge clk or negedge N_RESET) begin
    if (!N_RESET) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b1;
      fast_q   <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
    end else begin
      case (state)
        S_INIT, S_SHIFT: begin
          if (tick) begin
            div_cnt <= '0;
            sclk_q  <= ~sclk_q;
            if (edge_cnt != edge_last) edge_cnt <= edge_cnt + 1'b1;
            if (state == S_SHIFT) begin
              if (!sclk_q) begin
                // rising edge: capture the card's bit
                rx_shift <= {rx_shift[6:0], sdMISO};
              end else if (edge_cnt == SHIFT_LAST) begin
                // 8th falling edge: release MOSI high
                mosi_q <= 1'b1;
              end else begin
                mosi_q   <= tx_shift[6];
                tx_shift <= {tx_shift[5:0], 1'b1};
              end
              // last rising edge already happened, so rx_shift is complete
              if (edge_cnt == SHIFT_LAST) rx_data <= rx_shift;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (accept) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= tx_data[7];
            tx_shift <= tx_data[6:0];
            fast_q   <= fast;
          end
        end
        default: ;
      endcase
    end
  end

  // Activity stretch counter, reloaded on every accepted request
  always_ff @(posedge clk or negedge N_RESET) begin
    if (!N_RESET)              led_cnt <= '0;
    else if (accept)           led_cnt <= LED_LOAD;
    else if (led_cnt != '0)    led_cnt <= led_cnt - 1'b1;
  end

  assign busy     = (state == S_INIT) || (state == S_SHIFT);
  assign done     = (state == S_DONE);
  assign sdCS     = (state == S_INIT) ? 1'b1 : ~cs_req;
  assign sdSCLK   = sclk_q;
  assign sdMOSI   = mosi_q;
  assign driveLED = (led_cnt != '0) || (state == S_SHIFT);

endmodule

// File: tb/tb_sd_spi_ctrl.sv
// Directed bench for sd_spi_ctrl: INIT sequence, loopback and tied-MISO
// exchanges at both rates, start filtering, LED stretch, async reset.
module tb_sd_spi_ctrl;

  logic       clk = 1'b0;
  logic       N_RESET, start, fast, cs_req, sdMISO;
  logic [7:0] tx_data, rx_data;
  logic       busy, done, sdCS, sdSCLK, sdMOSI, driveLED;
  logic       loop_en, miso_val;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  assign sdMISO = loop_en ? sdMOSI : miso_val;

  sd_spi_ctrl #(
    .SLOW_DIV (62),
    .FAST_DIV (1),
    .INIT_CLKS(80),
    .LED_HOLD (100)
  ) dut (
    .clk     (clk),
    .N_RESET (N_RESET),
    .start   (start),
    .tx_data (tx_data),
    .fast    (fast),
    .cs_req  (cs_req),
    .rx_data (rx_data),
    .busy    (busy),
    .done    (done),
    .sdCS    (sdCS),
    .sdSCLK  (sdSCLK),
    .sdMOSI  (sdMOSI),
    .sdMISO  (sdMISO),
    .driveLED(driveLED)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Follows INIT from reset release until busy drops; optional start pulse.
  task automatic run_init(input int start_at, output int cyc, output int rises,
                          output int cs_bad, output int mosi_bad, output int led_on,
                          output int dones);
    logic prev;
    prev = sdSCLK;
    cyc = 0; rises = 0; cs_bad = 0; mosi_bad = 0; led_on = 0; dones = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = (cyc == start_at) ? 1'b1 : 1'b0;
      if (sdSCLK === 1'b1 && prev === 1'b0) rises++;
      prev = sdSCLK;
      if (busy === 1'b1 && sdCS !== 1'b1) cs_bad++;
      if (busy === 1'b1 && sdMOSI !== 1'b1) mosi_bad++;
      if (driveLED !== 1'b0) led_on++;
      if (done !== 1'b0) dones++;
    end while (busy === 1'b1 && cyc < 20000);
    start = 1'b0;
  endtask

  // One exchange; returns at the negedge where done is seen (lat = -1 on timeout).
  task automatic xfer(input logic [7:0] tx, input logic f, input int mid_k,
                      output int lat, output logic [7:0] mbits, output logic [7:0] rxd,
                      output logic bsy, output int cs_bad, output int fr, output int lr,
                      output logic led1);
    logic prev;
    tx_data = tx; fast = f; start = 1'b1;
    lat = 0; mbits = '0; cs_bad = 0; fr = 0; lr = 0; led1 = 1'b0; prev = sdSCLK;
    do begin
      @(negedge clk);
      lat++;
      if (lat == mid_k) begin
        start = 1'b1; tx_data = 8'h00; fast = ~f;
      end else begin
        start = 1'b0;
      end
      if (lat == 1) led1 = driveLED;
      if (sdSCLK === 1'b1 && prev === 1'b0) begin
        mbits = {mbits[6:0], sdMOSI};
        if (fr == 0) fr = lat;
        lr = lat;
      end
      prev = sdSCLK;
      if (sdCS !== 1'b0) cs_bad++;
    end while (done !== 1'b1 && lat < 3000);
    rxd = rx_data;
    bsy = busy;
    if (done !== 1'b1) lat = -1;
  endtask

  initial begin
    int cyc, rises, cs_bad, mosi_bad, led_on, dones, cnt;
    int lat, fr, lr;
    logic [7:0] mbits, rxd;
    logic bsy, led1;

    N_RESET = 1'b0; start = 1'b0; tx_data = 8'h00; fast = 1'b0;
    cs_req = 1'b1; loop_en = 1'b1; miso_val = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_sclk", sdSCLK, 1'b0);
    check("rst_mosi", sdMOSI, 1'b1);
    check("rst_cs", sdCS, 1'b1);
    check("rst_busy", busy, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_rx", rx_data, 8'h00);
    check("rst_led", driveLED, 1'b0);

    // INIT: 80 clocks of 126 cycles, CS/MOSI high, start ignored
    N_RESET = 1'b1;
    run_init(500, cyc, rises, cs_bad, mosi_bad, led_on, dones);
    check("init_cycles", cyc, 10080);
    check("init_rises", rises, 80);
    check("init_cs_high", cs_bad, 0);
    check("init_mosi_high", mosi_bad, 0);
    check("init_led_off", led_on, 0);
    check("init_no_done", dones, 0);
    check("init_sclk_idle", sdSCLK, 1'b0);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) cnt++;
    end
    check("init_start_ignored", cnt, 0);

    // fast loopback A5 with a mid-transfer start and input changes
    loop_en = 1'b1;
    xfer(8'hA5, 1'b1, 10, lat, mbits, rxd, bsy, cs_bad, fr, lr, led1);
    check("a5_latency", lat, 33);
    check("a5_mosi_bits", mbits, 8'hA5);
    check("a5_rx", rxd, 8'hA5);
    check("a5_busy_done", bsy, 1'b0);
    check("a5_cs_low", cs_bad, 0);
    check("a5_first_rise", fr, 3);
    check("a5_rise_span", lr - fr, 28);
    check("a5_led_entry", led1, 1'b1);
    @(negedge clk);
    check("a5_done_pulse", done, 1'b0);
    repeat (66) @(negedge clk);
    check("a5_led_hold_on", driveLED, 1'b1);
    @(negedge clk);
    check("a5_led_hold_off", driveLED, 1'b0);

    // slow, MISO tied low, second start mid-transfer ignored
    loop_en = 1'b0; miso_val = 1'b0;
    xfer(8'hFF, 1'b0, 500, lat, mbits, rxd, bsy, cs_bad, fr, lr, led1);
    check("ff_latency", lat, 1009);
    check("ff_rx", rxd, 8'h00);
    check("ff_mosi_bits", mbits, 8'hFF);
    check("ff_first_rise", fr, 64);
    check("ff_rise_span", lr - fr, 882);
    cnt = 0;
    repeat (1100) begin
      @(negedge clk);
      if (done !== 1'b0) cnt++;
    end
    check("ff_single_done", cnt, 0);

    // back-to-back: start on done cycle dropped, next cycle accepted
    loop_en = 1'b1;
    xfer(8'h3C, 1'b1, 0, lat, mbits, rxd, bsy, cs_bad, fr, lr, led1);
    check("b2b_3c_latency", lat, 33);
    check("b2b_3c_rx", rxd, 8'h3C);
    start = 1'b1; tx_data = 8'hFF; fast = 1'b1;
    @(negedge clk);
    xfer(8'hC3, 1'b1, 0, lat, mbits, rxd, bsy, cs_bad, fr, lr, led1);
    check("b2b_c3_latency", lat, 33);
    check("b2b_c3_rx", rxd, 8'hC3);
    check("b2b_c3_mosi_bits", mbits, 8'hC3);
    repeat (67) @(negedge clk);
    check("led_reload_on", driveLED, 1'b1);
    @(negedge clk);
    check("led_reload_off", driveLED, 1'b0);

    // async reset during half-period 7 of a transfer
    tx_data = 8'h5A; fast = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("mid_pre_led", driveLED, 1'b1);
    check("mid_pre_cs", sdCS, 1'b0);
    #3 N_RESET = 1'b0;
    #1;
    check("mid_rst_sclk", sdSCLK, 1'b0);
    check("mid_rst_mosi", sdMOSI, 1'b1);
    check("mid_rst_cs", sdCS, 1'b1);
    check("mid_rst_busy", busy, 1'b1);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_rx", rx_data, 8'h00);
    check("mid_rst_led", driveLED, 1'b0);
    repeat (2) @(negedge clk);
    N_RESET = 1'b1;
    run_init(0, cyc, rises, cs_bad, mosi_bad, led_on, dones);
    check("reinit_cycles", cyc, 10080);
    check("reinit_rises", rises, 80);
    check("reinit_no_done", dones, 0);
    check("reinit_cs_high", cs_bad, 0);
    check("reinit_mosi_high", mosi_bad, 0);
    check("reinit_led_off", led_on, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
